// File: rtl/earom_pkg.sv
// Shared definitions for the EAROM controller: CPU mode encodings and FSM states.
package earom_pkg;

  // {c1, c2} mode encodings seen on the CPU bus
  typedef enum logic [1:0] {
    MODE_WRITE   = 2'b00,
    MODE_ERASE   = 2'b01,
    MODE_READ    = 2'b10,
    MODE_STANDBY = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_ERASE,
    ST_HOST
  } state_e;

  function automatic mode_e decode_mode(input logic c1, input logic c2);
    return mode_e'({c1, c2});
  endfunction

endpackage

// File: rtl/earom_mem.sv
// Single-port word store with synchronous read and write; contents survive reset.
module earom_mem #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Write on we, and register the addressed word every cycle (old data on a write)
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/earom_ctrl.sv
// EAROM controller: CPU read/write/erase with busy timing, host save/load port,
// sticky dirty flag, and CPU-over-host arbitration in front of a single-port store.
module earom_ctrl
  import earom_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 6,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       WRITE_CYCLES = 4,
  parameter int unsigned       ERASE_CYCLES = 4,
  parameter logic [DATA_W-1:0] ERASE_VAL    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  input  logic              cs,
  input  logic              c1,
  input  logic              c2,
  input  logic              strobe,
  output logic              busy,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic [DATA_W-1:0] hs_din,
  output logic [DATA_W-1:0] hs_dout,
  input  logic              hs_req,
  input  logic              hs_we,
  output logic              hs_ack,
  output logic              dirty,
  input  logic              dirty_clr
);

  localparam int unsigned MAX_CYC = (WRITE_CYCLES > ERASE_CYCLES) ? WRITE_CYCLES : ERASE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] hs_dout_q, hs_dout_d;
  logic              hs_ack_q, hs_ack_d;
  logic              host_we_q, host_we_d;
  logic              dirty_q, dirty_d;

  mode_e             mode;
  logic              cpu_go;
  logic              commit;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  assign mode   = decode_mode(c1, c2);
  assign cpu_go = strobe && cs && (mode != MODE_STANDBY);

  earom_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Next-state, memory port steering, timer and output register updates
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    din_d     = din_q;
    timer_d   = timer_q;
    busy_d    = busy_q;
    dout_d    = dout_q;
    hs_dout_d = hs_dout_q;
    hs_ack_d  = 1'b0;
    host_we_d = host_we_q;
    commit    = 1'b0;
    mem_addr  = hs_addr;
    mem_we    = 1'b0;
    mem_wdata = hs_din;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_go) begin
          a_d   = a;
          din_d = din;
          // The store is addressed with the live CPU address on the strobe edge so
          // read data is ready to register on the following edge; a_q serves
          // only the deferred write/erase commit.
          mem_addr = a;
          unique case (mode)
            MODE_READ: begin
              state_d = ST_READ;
            end
            MODE_WRITE: begin
              state_d = ST_WRITE;
              busy_d  = 1'b1;
              timer_d = TMR_W'(WRITE_CYCLES);
            end
            MODE_ERASE: begin
              state_d = ST_ERASE;
              busy_d  = 1'b1;
              timer_d = TMR_W'(ERASE_CYCLES);
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else if (hs_req && !hs_ack_q) begin
          // hs_ack_q blocks re-acceptance while the host still holds hs_req
          state_d   = ST_HOST;
          host_we_d = hs_we;
          mem_addr  = hs_addr;
          mem_we    = hs_we;
          mem_wdata = hs_din;
        end
      end

      ST_READ: begin
        dout_d  = mem_rdata;
        state_d = ST_IDLE;
      end

      ST_WRITE, ST_ERASE: begin
        mem_addr  = a_q;
        mem_wdata = (state_q == ST_ERASE) ? ERASE_VAL : din_q;
        if (timer_q <= TMR_W'(1)) begin
          mem_we  = 1'b1;
          commit  = 1'b1;
          busy_d  = 1'b0;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      ST_HOST: begin
        if (!host_we_q) begin
          hs_dout_d = mem_rdata;
        end
        hs_ack_d = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        timer_d = '0;
      end
    endcase

    // A commit in the same cycle as a clear keeps the flag set
    if (commit) begin
      dirty_d = 1'b1;
    end else if (dirty_clr) begin
      dirty_d = 1'b0;
    end else begin
      dirty_d = dirty_q;
    end
  end

  // FSM and registered outputs; reset aborts any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      din_q     <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      dout_q    <= '0;
      hs_dout_q <= '0;
      hs_ack_q  <= 1'b0;
      host_we_q <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      din_q     <= din_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      dout_q    <= dout_d;
      hs_dout_q <= hs_dout_d;
      hs_ack_q  <= hs_ack_d;
      host_we_q <= host_we_d;
      dirty_q   <= dirty_d;
    end
  end

  assign dout    = dout_q;
  assign hs_dout = hs_dout_q;
  assign busy    = busy_q;
  assign hs_ack  = hs_ack_q;
  assign dirty   = dirty_q;

endmodule

// File: tb/tb_earom_ctrl.sv
// Scoreboard bench for earom_ctrl: stimulus queues expectations, a monitor checks them.
`timescale 1ns/1ps
module tb_earom_ctrl;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned WC = 4;
  localparam int unsigned EC = 4;

  localparam int K_DOUT  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_DIRTY = 2;
  localparam int K_HSACK = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] a = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          cs = 1'b0;
  logic          c1 = 1'b1;
  logic          c2 = 1'b1;
  logic          strobe = 1'b0;
  logic          busy;
  logic [AW-1:0] hs_addr = '0;
  logic [DW-1:0] hs_din = '0;
  logic [DW-1:0] hs_dout;
  logic          hs_req = 1'b0;
  logic          hs_we = 1'b0;
  logic          hs_ack;
  logic          dirty;
  logic          dirty_clr = 1'b0;

  earom_ctrl #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .WRITE_CYCLES (WC),
    .ERASE_CYCLES (EC),
    .ERASE_VAL    (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .din       (din),
    .dout      (dout),
    .cs        (cs),
    .c1        (c1),
    .c2        (c2),
    .strobe    (strobe),
    .busy      (busy),
    .hs_addr   (hs_addr),
    .hs_din    (hs_din),
    .hs_dout   (hs_dout),
    .hs_req    (hs_req),
    .hs_we     (hs_we),
    .hs_ack    (hs_ack),
    .dirty     (dirty),
    .dirty_clr (dirty_clr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int unsigned due;
    int          kind;
    logic [7:0]  exp;
    string       name;
  } chk_t;

  typedef struct {
    logic       is_read;
    logic [7:0] exp;
    string      name;
  } hchk_t;

  chk_t  tq[$];
  hchk_t hq[$];

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endfunction

  function automatic void expect_at(int unsigned due, int kind, logic [7:0] exp, string name);
    chk_t e;
    e.due  = due;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    tq.push_back(e);
  endfunction

  // Monitor: timed expectations, plus host responses popped on every hs_ack
  initial begin
    int    i;
    hchk_t h;
    forever begin
      @(negedge clk);
      i = 0;
      while (i < tq.size()) begin
        if (tq[i].due == cyc) begin
          case (tq[i].kind)
            K_DOUT:  chk(tq[i].name, dout, tq[i].exp);
            K_BUSY:  chk(tq[i].name, {7'b0, busy}, tq[i].exp);
            K_DIRTY: chk(tq[i].name, {7'b0, dirty}, tq[i].exp);
            default: chk(tq[i].name, {7'b0, hs_ack}, tq[i].exp);
          endcase
          tq.delete(i);
        end else begin
          i++;
        end
      end
      if (hs_ack) begin
        if (hq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL hs_ack_unexpected: got 1 expected 0");
        end else begin
          h = hq.pop_front();
          chk({h.name, "_busy"}, {7'b0, busy}, 8'h00);
          if (h.is_read) chk(h.name, hs_dout, h.exp);
        end
      end
    end
  end

  task automatic cpu_op(input logic [1:0] m, input logic cs_v, input logic [AW-1:0] ad,
                        input logic [DW-1:0] d);
    a      = ad;
    din    = d;
    c1     = m[1];
    c2     = m[0];
    cs     = cs_v;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    cs     = 1'b0;
    c1     = 1'b1;
    c2     = 1'b1;
  endtask

  task automatic cpu_read(input logic [AW-1:0] ad, input logic [7:0] exp, input string name);
    int unsigned c;
    c = cyc;
    expect_at(c + 1, K_BUSY, 8'h00, {name, "_busy"});
    expect_at(c + 2, K_DOUT, exp, name);
    cpu_op(2'b10, 1'b1, ad, 8'h00);
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] m, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                           input int unsigned n, input string name);
    int unsigned c;
    c = cyc;
    expect_at(c + 1, K_BUSY, 8'h01, {name, "_busy_first"});
    expect_at(c + n, K_BUSY, 8'h01, {name, "_busy_last"});
    expect_at(c + n + 1, K_BUSY, 8'h00, {name, "_busy_fall"});
    expect_at(c + n + 1, K_DIRTY, 8'h01, {name, "_dirty"});
    cpu_op(m, 1'b1, ad, d);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_txn(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d,
                          input logic [7:0] exp, input string name);
    hchk_t h;
    int    k;
    logic  got;
    h.is_read = !we;
    h.exp     = exp;
    h.name    = name;
    hq.push_back(h);
    hs_addr = ad;
    hs_din  = d;
    hs_we   = we;
    hs_req  = 1'b1;
    got     = 1'b0;
    k       = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      got = hs_ack;
      k++;
    end
    hs_req = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no hs_ack expected hs_ack within 40 cycles", name);
    end
  endtask

  task automatic clear_dirty(input string name);
    dirty_clr = 1'b1;
    expect_at(cyc + 1, K_DIRTY, 8'h00, name);
    @(negedge clk);
    dirty_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int unsigned c;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 8'h00);
    chk("rst_hs_dout", hs_dout, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    chk("rst_hs_ack", {7'b0, hs_ack}, 8'h00);
    chk("rst_dirty", {7'b0, dirty}, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // Host write then CPU read with two-edge latency; dirty untouched
    host_txn(1'b1, 6'd3, 8'h5A, 8'h00, "hw_a3");
    expect_at(cyc + 1, K_DOUT, 8'h00, "rd_a3_first_edge");
    expect_at(cyc + 2, K_DIRTY, 8'h00, "dirty_after_host_wr");
    cpu_read(6'd3, 8'h5A, "rd_a3");

    // CPU write with a/din changed after strobe and a strobe during busy
    host_txn(1'b1, 6'd11, 8'h21, 8'h00, "hw_a11");
    host_txn(1'b1, 6'd12, 8'h34, 8'h00, "hw_a12");
    c = cyc;
    expect_at(c + 1, K_BUSY, 8'h01, "wr10_busy_first");
    expect_at(c + 3, K_BUSY, 8'h01, "wr10_busy_mid");
    expect_at(c + WC, K_BUSY, 8'h01, "wr10_busy_last");
    expect_at(c + WC + 1, K_BUSY, 8'h00, "wr10_busy_fall");
    expect_at(c + WC, K_DIRTY, 8'h00, "wr10_dirty_pre");
    expect_at(c + WC + 1, K_DIRTY, 8'h01, "wr10_dirty_set");
    cpu_op(2'b00, 1'b1, 6'd10, 8'hC3);
    a   = 6'd11;
    din = 8'hFF;
    @(negedge clk);
    cpu_op(2'b00, 1'b1, 6'd12, 8'h77);
    repeat (WC - 2) @(negedge clk);
    cpu_read(6'd10, 8'hC3, "rd_a10_written");
    cpu_read(6'd12, 8'h34, "rd_a12_ignored_strobe");
    cpu_read(6'd11, 8'h21, "rd_a11_latched_addr");
    clear_dirty("dirty_clr_after_wr");

    // Erase with dirty_clr coinciding with the commit edge
    c = cyc;
    expect_at(c + 1, K_BUSY, 8'h01, "er10_busy_first");
    expect_at(c + EC, K_BUSY, 8'h01, "er10_busy_last");
    expect_at(c + EC + 1, K_BUSY, 8'h00, "er10_busy_fall");
    expect_at(c + EC + 1, K_DIRTY, 8'h01, "er10_dirty_set_wins");
    cpu_op(2'b01, 1'b1, 6'd10, 8'hAB);
    repeat (EC - 1) @(negedge clk);
    dirty_clr = 1'b1;
    @(negedge clk);
    dirty_clr = 1'b0;
    cpu_read(6'd10, 8'h00, "rd_a10_erased");
    clear_dirty("dirty_clr_after_er");

    // Simultaneous host read and CPU write: CPU first, host acked afterwards
    host_txn(1'b1, 6'd20, 8'h99, 8'h00, "hw_a20");
    c = cyc;
    expect_at(c + WC + 2, K_HSACK, 8'h00, "arb_hs_ack_not_yet");
    expect_at(c + WC + 3, K_HSACK, 8'h01, "arb_hs_ack_after_busy");
    fork
      host_txn(1'b0, 6'd20, 8'h00, 8'h66, "hr_a20_after_cpu");
      cpu_write(2'b00, 6'd20, 8'h66, WC, "wr20");
    join
    repeat (2) @(negedge clk);

    // Reset in the middle of a write aborts it and leaves the old word
    host_txn(1'b1, 6'd7, 8'h11, 8'h00, "hw_a7");
    cpu_read(6'd20, 8'h66, "rd_a20");
    cpu_op(2'b00, 1'b1, 6'd7, 8'hEE);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {7'b0, busy}, 8'h00);
    chk("rst_mid_dirty", {7'b0, dirty}, 8'h00);
    chk("rst_mid_dout", dout, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cpu_read(6'd7, 8'h11, "rd_a7_after_abort");

    // Standby mode and cs=0 strobes do nothing
    cpu_read(6'd3, 8'h5A, "rd_a3_again");
    c = cyc;
    expect_at(c + 1, K_BUSY, 8'h00, "noop_standby_busy");
    expect_at(c + 2, K_DOUT, 8'h5A, "noop_standby_dout");
    cpu_op(2'b11, 1'b1, 6'd7, 8'h55);
    @(negedge clk);
    c = cyc;
    expect_at(c + 2, K_DOUT, 8'h5A, "noop_cs0_read_dout");
    cpu_op(2'b10, 1'b0, 6'd7, 8'h00);
    @(negedge clk);
    c = cyc;
    expect_at(c + 1, K_BUSY, 8'h00, "noop_cs0_wr_busy");
    expect_at(c + WC + 1, K_DIRTY, 8'h00, "noop_cs0_wr_dirty");
    cpu_op(2'b00, 1'b0, 6'd7, 8'h55);
    repeat (WC) @(negedge clk);
    cpu_read(6'd7, 8'h11, "rd_a7_unchanged");

    // dout holds across a host read
    host_txn(1'b0, 6'd3, 8'h00, 8'h5A, "hr_a3");
    chk("dout_hold_host", dout, 8'h11);

    repeat (5) @(negedge clk);
    foreach (tq[j]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_pending: got no check expected check at cycle %0d", tq[j].name, tq[j].due);
    end
    foreach (hq[j]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_pending: got no hs_ack expected hs_ack", hq[j].name);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
